// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch queue: instruction width and PC step.
package ifetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, a flush that empties it in one cycle and a combinational head.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [WIDTH-1:0]         head
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues ROM reads under a credit rule and queues returned words for decode.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc_plus_4
);
  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_4;
  } entry_t;

  logic [ADDR_W-1:0] fpc, inflight_pc, redirect_fpc;
  logic              inflight, issue, push, pop, empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  entry_t            push_entry, head;

  // A slot is reserved for every outstanding read, so a returning word always finds room.
  assign credit_used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue        = rst && !redirect && (credit_used < DEPTH_L);
  assign push         = inflight && !redirect;
  assign pop          = !empty && out_ready && !redirect;
  assign redirect_fpc = redirect_pc & ~ADDR_W'(3);

  assign push_entry.instr     = imem_rdata;
  assign push_entry.pc_plus_4 = inflight_pc + STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fpc;
      if (redirect)   fpc <= redirect_fpc;
      else if (issue) fpc <= fpc + STEP;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .count (count),
    .empty (empty),
    .head  (head)
  );

  assign imem_req      = issue;
  assign imem_addr     = fpc[IMEM_AW+1:2];
  assign out_valid     = !empty;
  assign out_instr     = empty ? '0 : head.instr;
  assign out_pc_plus_4 = empty ? '0 : head.pc_plus_4;
endmodule
